// File: rtl/fifo_frame_writer_pkg.sv
// Shared types and parameter defaults for the frame writer slice.
// Consumers: fifo_frame_writer_if, fifo_frame_checksum, fifo_frame_writer.
package fifo_frame_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TRAILER
  } fw_state_t;

  localparam int FW_DATA_WIDTH_DEFAULT = 8;
  localparam int FW_LEN_WIDTH_DEFAULT  = 8;
  localparam int FW_CNT_WIDTH_DEFAULT  = 16;

  // The header word carries the length, so the length field must fit in one FIFO word.
  function automatic bit fw_len_fits(input int len_w, input int data_w);
    return (len_w >= 1) && (len_w <= data_w);
  endfunction

endpackage

// File: rtl/fifo_frame_writer_if.sv
// Payload stream plus FIFO write port of the frame writer.
// master = the writer itself, slave = payload source / FIFO side.
interface fifo_frame_writer_if
  import fifo_frame_writer_pkg::*;
#(
  parameter int DATA_WIDTH = FW_DATA_WIDTH_DEFAULT
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;

  modport master (input s_valid, s_data, full, output s_ready, wr_en, din);
  modport slave  (output s_valid, s_data, full, input s_ready, wr_en, din);
endinterface

// File: rtl/fifo_frame_checksum.sv
// Modular running sum of the payload words of one frame.
// Only instantiated when FIFO_FRAME_WRITER_CHECKSUM_EN is defined.
module fifo_frame_checksum
  import fifo_frame_writer_pkg::*;
#(
  parameter int DATA_WIDTH = FW_DATA_WIDTH_DEFAULT
) (
  input  logic                  reset,
  input  logic                  wr_clk,
  input  logic                  clear,
  input  logic                  add,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] sum
);
  logic [DATA_WIDTH-1:0] sum_reg;

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      sum_reg <= '0;
    end else if (clear) begin
      sum_reg <= '0;
    end else if (add) begin
      sum_reg <= sum_reg + data;
    end
  end

  assign sum = sum_reg;
endmodule

// File: rtl/fifo_frame_writer.sv
// Frame producer for the write side of the dual-clock FIFO: header, payload, optional trailer.
// Define FIFO_FRAME_WRITER_CHECKSUM_EN to append a two's-complement checksum trailer word.
module fifo_frame_writer
  import fifo_frame_writer_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = FW_DATA_WIDTH_DEFAULT,
  parameter int LEN_WIDTH       = FW_LEN_WIDTH_DEFAULT,
  parameter int CNT_WIDTH       = FW_CNT_WIDTH_DEFAULT
) (
  input  logic                 reset,
  input  logic                 wr_clk,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] start_len,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] frame_count,
  fifo_frame_writer_if.master  bus
);

  if (!fw_len_fits(LEN_WIDTH, FIFO_DATA_WIDTH)) begin : g_len_check
    $error("fifo_frame_writer: LEN_WIDTH must be within 1..FIFO_DATA_WIDTH");
  end

  fw_state_t            state_reg, state_next;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] remaining_reg;
  logic                 done_reg;
  logic [CNT_WIDTH-1:0] frame_count_reg;

  logic                       load;
  logic                       accept;
  logic                       finish;
  logic [FIFO_DATA_WIDTH-1:0] len_word;

  assign len_word = FIFO_DATA_WIDTH'(len_reg);

`ifdef FIFO_FRAME_WRITER_CHECKSUM_EN
  localparam bit HAS_TRAILER = 1'b1;
  logic [FIFO_DATA_WIDTH-1:0] checksum;

  fifo_frame_checksum #(
    .DATA_WIDTH(FIFO_DATA_WIDTH)
  ) u_checksum (
    .reset (reset),
    .wr_clk(wr_clk),
    .clear (load),
    .add   (accept),
    .data  (bus.s_data),
    .sum   (checksum)
  );
`else
  localparam bit HAS_TRAILER = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    bus.s_ready = 1'b0;
    bus.wr_en   = 1'b0;
    bus.din     = '0;
    load        = 1'b0;
    accept      = 1'b0;
    finish      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_HEADER;
        end
      end
      ST_HEADER: begin
        bus.wr_en = !bus.full;
        bus.din   = len_word;
        if (!bus.full) begin
          if (len_reg != '0) begin
            state_next = ST_PAYLOAD;
          end else if (HAS_TRAILER) begin
            state_next = ST_TRAILER;
          end else begin
            state_next = ST_IDLE;
            finish     = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        bus.s_ready = !bus.full;
        bus.wr_en   = bus.s_valid && !bus.full;
        bus.din     = bus.s_data;
        if (bus.s_valid && !bus.full) begin
          accept = 1'b1;
          if (remaining_reg == LEN_WIDTH'(1)) begin
            if (HAS_TRAILER) begin
              state_next = ST_TRAILER;
            end else begin
              state_next = ST_IDLE;
              finish     = 1'b1;
            end
          end
        end
      end
`ifdef FIFO_FRAME_WRITER_CHECKSUM_EN
      ST_TRAILER: begin
        // Trailer makes the modular sum of payload plus trailer equal zero.
        bus.wr_en = !bus.full;
        bus.din   = '0 - checksum;
        if (!bus.full) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      len_reg         <= '0;
      remaining_reg   <= '0;
      done_reg        <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= finish;
      if (finish) begin
        frame_count_reg <= frame_count_reg + 1'b1;
      end
      if (load) begin
        len_reg       <= start_len;
        remaining_reg <= start_len;
      end else if (accept) begin
        remaining_reg <= remaining_reg - 1'b1;
      end
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Self-checking bench for fifo_frame_writer; expected FIFO contents come from a frame-level model.
// Compile with FIFO_FRAME_WRITER_CHECKSUM_EN defined to check the trailer build.
module tb_fifo_frame_writer;
  import fifo_frame_writer_pkg::*;

  logic        reset;
  logic        wr_clk;
  logic        start;
  logic [7:0]  start_len;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_frames = 0;
  logic [7:0] pay [0:255];

  fifo_frame_writer_if #(.DATA_WIDTH(8)) bus ();

  fifo_frame_writer #(
    .FIFO_DATA_WIDTH(8),
    .LEN_WIDTH      (8),
    .CNT_WIDTH      (16)
  ) dut (
    .reset      (reset),
    .wr_clk     (wr_clk),
    .start      (start),
    .start_len  (start_len),
    .busy       (busy),
    .done       (done),
    .frame_count(frame_count),
    .bus        (bus)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic fill_payload(input int len);
    for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1 reset = 1'b0;
    exp_frames = 0;
  endtask

  // gap_mode: 0 always valid, 1 every other cycle, 2 random
  // full_mode: 0 never, 1 window [full_at, full_at+full_len), 2 random
  task automatic run_frame(input string name, input int len, input int gap_mode,
                           input int full_mode, input int full_at, input int full_len,
                           input int busy_start_at);
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int sum, tr, idx, cyc, stall_bad, busy_bad, sready_seen;
    bit done_seen, valid_ok;
    sum = 0; idx = 0; cyc = 0; stall_bad = 0; busy_bad = 0; sready_seen = 0;
    done_seen = 1'b0;

    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay[i]);
      sum += int'(pay[i]);
    end
`ifdef FIFO_FRAME_WRITER_CHECKSUM_EN
    tr = (256 - (sum % 256)) % 256;
    exp_q.push_back(8'(tr));
`else
    tr = 0;
`endif

    start = 1'b1;
    start_len = 8'(len);
    bus.s_valid = 1'b0;
    bus.full = 1'b0;
    @(posedge wr_clk);
    #1 start = 1'b0;

    while (!done_seen && cyc < 400) begin
      case (full_mode)
        1: bus.full = (cyc >= full_at) && (cyc < full_at + full_len);
        2: bus.full = ($urandom_range(3) == 0);
        default: bus.full = 1'b0;
      endcase
      case (gap_mode)
        1: valid_ok = (cyc % 2 == 0);
        2: valid_ok = 1'(($urandom_range(1)));
        default: valid_ok = 1'b1;
      endcase
      bus.s_valid = (idx < len) && valid_ok;
      bus.s_data  = (idx < len) ? pay[idx] : 8'h00;
      start = (cyc == busy_start_at);
      start_len = 8'($urandom);
      @(negedge wr_clk);
      if (bus.full && (bus.wr_en || bus.s_ready)) stall_bad++;
      if (bus.wr_en && !bus.full) cap_q.push_back(bus.din);
      if (bus.s_valid && bus.s_ready) idx++;
      if (bus.s_ready) sready_seen++;
      if (done) begin
        done_seen = 1'b1;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
      @(posedge wr_clk);
      #1 cyc++;
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.full = 1'b0;

    $display("[TB] %s: len=%0d words=%0d expected_words=%0d cycles=%0d",
             name, len, cap_q.size(), exp_q.size(), cyc);
    if (done_seen) exp_frames++;

    tests_run++;
    if (!done_seen) begin
      tests_failed++;
      $display("FAIL %s done_timeout: got no done, required done within 400 cycles", name);
    end
    tests_run++;
    if (cap_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s word_count: got %0d, required %0d", name, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) begin
        tests_run++;
        if (cap_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL %s word[%0d]: got %02h, required %02h", name, i, cap_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (idx !== len) begin
      tests_failed++;
      $display("FAIL %s accepted: got %0d, required %0d", name, idx, len);
    end
    tests_run++;
    if (stall_bad !== 0) begin
      tests_failed++;
      $display("FAIL %s full_stall: got %0d cycles with wr_en/s_ready while full, required 0", name, stall_bad);
    end
    tests_run++;
    if (busy_bad !== 0) begin
      tests_failed++;
      $display("FAIL %s busy: got %0d bad cycles, required 0", name, busy_bad);
    end
    if (len == 0) begin
      tests_run++;
      if (sready_seen !== 0) begin
        tests_failed++;
        $display("FAIL %s s_ready_len0: got %0d high cycles, required 0", name, sready_seen);
      end
    end

    @(negedge wr_clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_pulse_width: got done=%0b one cycle later, required 0", name, done);
    end
    tests_run++;
    if (frame_count !== 16'(exp_frames)) begin
      tests_failed++;
      $display("FAIL %s frame_count: got %0d, required %0d", name, frame_count, exp_frames);
    end
    tests_run++;
    if ({busy, bus.wr_en, bus.din} !== 10'h000) begin
      tests_failed++;
      $display("FAIL %s idle_outputs: got busy=%0b wr_en=%0b din=%02h, required 0/0/00",
               name, busy, bus.wr_en, bus.din);
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start_len = 8'h00;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h5A;
    bus.full = 1'b0;
    repeat (2) @(negedge wr_clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0b, required 0", done); end
    tests_run++;
    if (frame_count !== 16'h0) begin tests_failed++; $display("FAIL reset_frame_count: got %0d, required 0", frame_count); end
    tests_run++;
    if (bus.s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready: got %0b, required 0", bus.s_ready); end
    tests_run++;
    if (bus.wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %0b, required 0", bus.wr_en); end
    tests_run++;
    if (bus.din !== 8'h00) begin tests_failed++; $display("FAIL reset_din: got %02h, required 00", bus.din); end
    bus.s_valid = 1'b0;
    @(posedge wr_clk);
    #1 reset = 1'b0;
    exp_frames = 0;
  endtask

  task automatic test_basic();
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    run_frame("basic_len3", 3, 0, 0, 0, 0, -1);
  endtask

  task automatic test_zero_len();
    run_frame("zero_len", 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_full_stall();
    fill_payload(4);
    run_frame("full_stall", 4, 0, 1, 3, 5, -1);
  endtask

  task automatic test_valid_gaps();
    fill_payload(8);
    run_frame("valid_gaps", 8, 1, 0, 0, 0, -1);
  endtask

  task automatic test_start_while_busy();
    apply_reset();
    fill_payload(6);
    run_frame("start_while_busy", 6, 0, 0, 0, 0, 3);
    fill_payload(2);
    run_frame("second_frame", 2, 0, 0, 0, 0, -1);
    tests_run++;
    if (frame_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL start_while_busy_count: got %0d, required 2", frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int idx;
    idx = 0;
    fill_payload(5);
    start = 1'b1;
    start_len = 8'd5;
    @(posedge wr_clk);
    #1 start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data = pay[idx];
      @(negedge wr_clk);
      if (bus.s_valid && bus.s_ready) idx++;
      @(posedge wr_clk);
      #1;
    end
    tests_run++;
    if (idx !== 2) begin tests_failed++; $display("FAIL midreset_accepted: got %0d, required 2", idx); end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, bus.s_ready, bus.wr_en} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midreset_flags: got busy=%0b done=%0b s_ready=%0b wr_en=%0b, required all 0",
               busy, done, bus.s_ready, bus.wr_en);
    end
    tests_run++;
    if (frame_count !== 16'h0) begin tests_failed++; $display("FAIL midreset_frame_count: got %0d, required 0", frame_count); end
    tests_run++;
    if (bus.din !== 8'h00) begin tests_failed++; $display("FAIL midreset_din: got %02h, required 00", bus.din); end
    bus.s_valid = 1'b0;
    @(posedge wr_clk);
    #1 reset = 1'b0;
    exp_frames = 0;
    fill_payload(1);
    run_frame("after_reset_len1", 1, 0, 0, 0, 0, -1);
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 16; f++) begin
      len = $urandom_range(12);
      fill_payload(len);
      run_frame("random", len, 2, 2, 0, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_full_stall();
    test_valid_gaps();
    test_start_while_busy();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
